// File: rtl/wembley_pkg.sv
// Shared framing constants and FSM state encoding for the wembley_88 link.
// Both the transmit serializer and the receiver import this package.
package wembley_pkg;

  localparam int NIB_W           = 4;
  localparam int NUM_NIB         = 3;
  localparam int FRAME_DATA_BITS = NIB_W * NUM_NIB;

  localparam logic START_BIT = 1'b1;
  localparam logic IDLE_BIT  = 1'b0;
  localparam logic STOP_BIT  = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2,
    STOP = 2'd3
  } state_e;

  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/wembley_88_rx_if.sv
// Serial line plus recovered-frame outputs of the wembley_88 receiver.
// The slave modport is the receiver side; master is the line driver / consumer.
interface wembley_88_rx_if #(
  parameter int NIB_W = wembley_pkg::NIB_W
);
  logic             Yin;
  logic [NIB_W-1:0] A_o;
  logic [NIB_W-1:0] B_o;
  logic [NIB_W-1:0] C_o;
  logic             valid_o;
  logic             frame_err_o;
  logic             parity_err_o;
  logic             busy_o;

  modport slave (
    input  Yin,
    output A_o, B_o, C_o, valid_o, frame_err_o, parity_err_o, busy_o
  );

  modport master (
    output Yin,
    input  A_o, B_o, C_o, valid_o, frame_err_o, parity_err_o, busy_o
  );
endinterface

// File: rtl/wembley_rx_shift.sv
// Data shift register with bit counter and running XOR parity.
// Parity accumulator port exists only when WEMBLEY_RX_PARITY_EN is defined.
module wembley_rx_shift #(
  parameter int WIDTH = 12,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             shift_en_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CNT_W-1:0] cnt_o
`ifdef WEMBLEY_RX_PARITY_EN
  ,
  output logic             par_o
`endif
);

  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             par_q, par_d;

  // The shift register needs no clear: every frame overwrites all WIDTH bits.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    if (clear_i) begin
      cnt_d = '0;
      par_d = 1'b0;
    end else if (shift_en_i) begin
      shift_d = {shift_q[WIDTH-2:0], bit_i};
      cnt_d   = cnt_q + CNT_W'(1);
      par_d   = par_q ^ bit_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
    end
  end

  assign data_o = shift_q;
  assign cnt_o  = cnt_q;
`ifdef WEMBLEY_RX_PARITY_EN
  assign par_o  = par_q;
`else
  logic unused_par;
  assign unused_par = par_q;
`endif

endmodule

// File: rtl/wembley_88_rx.sv
// wembley_88 serial receiver/deframer: start, 12 data bits, [parity], stop.
// Optional even parity enabled by defining WEMBLEY_RX_PARITY_EN.
module wembley_88_rx
  import wembley_pkg::*;
#(
  parameter int NIB_W   = wembley_pkg::NIB_W,
  parameter int NUM_NIB = wembley_pkg::NUM_NIB
) (
  input  logic            clk,
  input  logic            reset,
  wembley_88_rx_if.slave  bus
);

  localparam int DBITS = NIB_W * NUM_NIB;
  localparam int CNT_W = cnt_width(DBITS);

  state_e           state_q, state_d;
  logic             clear, shift_en, last_bit;
  logic [DBITS-1:0] data;
  logic [CNT_W-1:0] cnt;
  logic [NIB_W-1:0] a_q, b_q, c_q;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             perr_q, perr_d;
  logic             pflag_q, pflag_d;

`ifdef WEMBLEY_RX_PARITY_EN
  logic par_acc;
  wembley_rx_shift #(.WIDTH(DBITS), .CNT_W(CNT_W)) u_shift (
    .clk        (clk),
    .reset      (reset),
    .clear_i    (clear),
    .shift_en_i (shift_en),
    .bit_i      (bus.Yin),
    .data_o     (data),
    .cnt_o      (cnt),
    .par_o      (par_acc)
  );
`else
  wembley_rx_shift #(.WIDTH(DBITS), .CNT_W(CNT_W)) u_shift (
    .clk        (clk),
    .reset      (reset),
    .clear_i    (clear),
    .shift_en_i (shift_en),
    .bit_i      (bus.Yin),
    .data_o     (data),
    .cnt_o      (cnt)
  );
`endif

  assign last_bit = (cnt == CNT_W'(DBITS - 1));

  always_comb begin
    state_d  = state_q;
    clear    = 1'b0;
    shift_en = 1'b0;
    valid_d  = 1'b0;
    ferr_d   = 1'b0;
    perr_d   = 1'b0;
    pflag_d  = pflag_q;
    unique case (state_q)
      IDLE: begin
        if (bus.Yin == START_BIT) begin
          state_d = DATA;
          clear   = 1'b1;
        end
      end
      DATA: begin
        shift_en = 1'b1;
        if (last_bit) begin
`ifdef WEMBLEY_RX_PARITY_EN
          state_d = PAR;
`else
          state_d = STOP;
`endif
        end
      end
      PAR: begin
`ifdef WEMBLEY_RX_PARITY_EN
        pflag_d = bus.Yin ^ par_acc;
`endif
        state_d = STOP;
      end
      STOP: begin
        // A stop of 1 returns to IDLE; a new start must be sampled there afresh.
        ferr_d = (bus.Yin != STOP_BIT);
`ifdef WEMBLEY_RX_PARITY_EN
        perr_d = pflag_q;
`endif
        valid_d = !ferr_d && !perr_d;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
      pflag_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      perr_q  <= perr_d;
      pflag_q <= pflag_d;
      if (valid_d) begin
        a_q <= data[DBITS-1 -: NIB_W];
        b_q <= data[DBITS-1-NIB_W -: NIB_W];
        c_q <= data[DBITS-1-2*NIB_W -: NIB_W];
      end
    end
  end

  assign bus.A_o         = a_q;
  assign bus.B_o         = b_q;
  assign bus.C_o         = c_q;
  assign bus.valid_o     = valid_q;
  assign bus.frame_err_o = ferr_q;
  assign bus.busy_o      = (state_q != IDLE);
`ifdef WEMBLEY_RX_PARITY_EN
  assign bus.parity_err_o = perr_q;
`else
  logic unused_perr;
  assign unused_perr      = perr_q ^ pflag_q;
  assign bus.parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_wembley_88_rx.sv
// Self-checking bench for wembley_88_rx: directed scenarios plus random frames
// checked against a frame-level reference model (works with or without parity).
module tb_wembley_88_rx;

`ifdef WEMBLEY_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
  localparam int FLEN   = 15;
`else
  localparam bit PAR_EN = 1'b0;
  localparam int FLEN   = 14;
`endif

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  wembley_88_rx_if bus ();

  wembley_88_rx dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Observation side: pulse counts and valid timestamps.
  int cyc = 0;
  int n_valid = 0, n_ferr = 0, n_perr = 0;
  int vtimes[$];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (bus.valid_o === 1'b1) begin
      n_valid++;
      vtimes.push_back(cyc);
    end
    if (bus.frame_err_o === 1'b1) n_ferr++;
    if (bus.parity_err_o === 1'b1) n_perr++;
  end

  // Reference model state: last good nibbles.
  logic [3:0] exp_a = 4'h0, exp_b = 4'h0, exp_c = 4'h0;
  logic       exp_valid, exp_ferr, exp_perr;

  task automatic drive(input logic b);
    bus.Yin = b;
    @(posedge clk);
    #1;
  endtask

  // Sends one frame; returns at #1 after the edge that samples the stop bit.
  task automatic send_frame(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                            input logic stop, input logic pflip);
    logic [11:0] d;
    d = {a, b, c};
    drive(1'b1);
    for (int i = 11; i >= 0; i--) drive(d[i]);
    if (PAR_EN) drive((^d) ^ pflip);
    drive(stop);
  endtask

  // Frame-level rule: good iff stop bit is 0 and (if present) parity matches.
  task automatic model_frame(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                             input logic stop, input logic pflip);
    exp_ferr  = stop;
    exp_perr  = PAR_EN && pflip;
    exp_valid = !exp_ferr && !exp_perr;
    if (exp_valid) begin
      exp_a = a; exp_b = b; exp_c = c;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.Yin = 1'b0;
    drive(1'b0);
    drive(1'b0);
    checks++;
    if (bus.busy_o !== 1'b0 || bus.valid_o !== 1'b0 || bus.frame_err_o !== 1'b0 ||
        bus.parity_err_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: busy=%b valid=%b ferr=%b perr=%b, want all 0",
               bus.busy_o, bus.valid_o, bus.frame_err_o, bus.parity_err_o);
    end
    checks++;
    if ({bus.A_o, bus.B_o, bus.C_o} !== 12'h000) begin
      errors++;
      $display("FAIL reset_data: got %h%h%h want 000", bus.A_o, bus.B_o, bus.C_o);
    end
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b0);
      checks++;
      if (bus.busy_o !== 1'b0 || bus.valid_o !== 1'b0 ||
          {bus.A_o, bus.B_o, bus.C_o} !== 12'h000) begin
        errors++;
        $display("FAIL idle_line: cycle %0d busy=%b valid=%b data=%h%h%h want 0/0/000",
                 i, bus.busy_o, bus.valid_o, bus.A_o, bus.B_o, bus.C_o);
      end
    end
  endtask

  task automatic test_good_frame;
    int busy_seen;
    bus.Yin = 1'b1;
    @(posedge clk); #1;
    busy_seen = bus.busy_o;
    checks++;
    if (busy_seen !== 1) begin
      errors++;
      $display("FAIL busy_after_start: got %0d want 1", busy_seen);
    end
    for (int i = 11; i >= 0; i--) drive(12'hA3F >> i);
    if (PAR_EN) drive(^12'hA3F);
    drive(1'b0);
    model_frame(4'hA, 4'h3, 4'hF, 1'b0, 1'b0);
    checks++;
    if (bus.valid_o !== 1'b1 || bus.frame_err_o !== 1'b0 || bus.parity_err_o !== 1'b0) begin
      errors++;
      $display("FAIL good_frame_flags: valid=%b ferr=%b perr=%b want 1/0/0",
               bus.valid_o, bus.frame_err_o, bus.parity_err_o);
    end
    checks++;
    if (bus.A_o !== 4'hA || bus.B_o !== 4'h3 || bus.C_o !== 4'hF) begin
      errors++;
      $display("FAIL good_frame_data: got %h %h %h want A 3 F", bus.A_o, bus.B_o, bus.C_o);
    end
    drive(1'b0);
    checks++;
    if (bus.valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL valid_pulse_width: valid=%b busy=%b want 0/0", bus.valid_o, bus.busy_o);
    end
  endtask

  task automatic test_bad_stop;
    send_frame(4'h1, 4'h2, 4'h3, 1'b1, 1'b0);
    model_frame(4'h1, 4'h2, 4'h3, 1'b1, 1'b0);
    checks++;
    if (bus.frame_err_o !== 1'b1 || bus.valid_o !== 1'b0) begin
      errors++;
      $display("FAIL bad_stop_flags: ferr=%b valid=%b want 1/0", bus.frame_err_o, bus.valid_o);
    end
    checks++;
    if (bus.A_o !== 4'hA || bus.B_o !== 4'h3 || bus.C_o !== 4'hF) begin
      errors++;
      $display("FAIL bad_stop_hold: got %h %h %h want A 3 F", bus.A_o, bus.B_o, bus.C_o);
    end
    // Stop=1 must not act as a start: an idle line afterwards stays idle.
    drive(1'b0);
    drive(1'b0);
    checks++;
    if (bus.busy_o !== 1'b0 || bus.frame_err_o !== 1'b0) begin
      errors++;
      $display("FAIL stop_not_start: busy=%b ferr=%b want 0/0", bus.busy_o, bus.frame_err_o);
    end
  endtask

`ifdef WEMBLEY_RX_PARITY_EN
  task automatic test_parity;
    send_frame(4'h1, 4'h2, 4'h4, 1'b0, 1'b1);
    model_frame(4'h1, 4'h2, 4'h4, 1'b0, 1'b1);
    checks++;
    if (bus.parity_err_o !== 1'b1 || bus.valid_o !== 1'b0 || bus.frame_err_o !== 1'b0) begin
      errors++;
      $display("FAIL parity_bad: perr=%b valid=%b ferr=%b want 1/0/0",
               bus.parity_err_o, bus.valid_o, bus.frame_err_o);
    end
    drive(1'b0);
    send_frame(4'h1, 4'h2, 4'h4, 1'b0, 1'b0);
    model_frame(4'h1, 4'h2, 4'h4, 1'b0, 1'b0);
    checks++;
    if (bus.valid_o !== 1'b1 || bus.parity_err_o !== 1'b0 ||
        {bus.A_o, bus.B_o, bus.C_o} !== 12'h124) begin
      errors++;
      $display("FAIL parity_good: valid=%b perr=%b data=%h%h%h want 1/0/124",
               bus.valid_o, bus.parity_err_o, bus.A_o, bus.B_o, bus.C_o);
    end
    drive(1'b0);
    send_frame(4'h7, 4'h0, 4'h0, 1'b1, 1'b1);
    checks++;
    if (bus.parity_err_o !== 1'b1 || bus.frame_err_o !== 1'b1 || bus.valid_o !== 1'b0) begin
      errors++;
      $display("FAIL both_errors: perr=%b ferr=%b valid=%b want 1/1/0",
               bus.parity_err_o, bus.frame_err_o, bus.valid_o);
    end
    drive(1'b0);
  endtask
`endif

  task automatic test_back_to_back;
    int q0;
    q0 = vtimes.size();
    send_frame(4'h5, 4'h6, 4'h7, 1'b0, 1'b0);
    model_frame(4'h5, 4'h6, 4'h7, 1'b0, 1'b0);
    checks++;
    if (bus.valid_o !== 1'b1 || {bus.A_o, bus.B_o, bus.C_o} !== {exp_a, exp_b, exp_c}) begin
      errors++;
      $display("FAIL b2b_first: valid=%b data=%h%h%h want 1/567",
               bus.valid_o, bus.A_o, bus.B_o, bus.C_o);
    end
    send_frame(4'h8, 4'h9, 4'hA, 1'b0, 1'b0);
    model_frame(4'h8, 4'h9, 4'hA, 1'b0, 1'b0);
    checks++;
    if (bus.valid_o !== 1'b1 || {bus.A_o, bus.B_o, bus.C_o} !== {exp_a, exp_b, exp_c}) begin
      errors++;
      $display("FAIL b2b_second: valid=%b data=%h%h%h want 1/89a",
               bus.valid_o, bus.A_o, bus.B_o, bus.C_o);
    end
    drive(1'b0);
    checks++;
    if (vtimes.size() != q0 + 2) begin
      errors++;
      $display("FAIL b2b_count: got %0d valid pulses want 2", vtimes.size() - q0);
    end else if (vtimes[q0+1] - vtimes[q0] != FLEN) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d clocks want %0d", vtimes[q0+1] - vtimes[q0], FLEN);
    end
  endtask

  task automatic test_reset_mid;
    int v0, f0, p0;
    v0 = n_valid; f0 = n_ferr; p0 = n_perr;
    drive(1'b1);
    for (int i = 5; i >= 0; i--) drive(6'b101100 >> i);
    reset = 1'b1;
    drive(1'b0);
    drive(1'b0);
    reset = 1'b0;
    exp_a = 4'h0; exp_b = 4'h0; exp_c = 4'h0;
    for (int i = 0; i < 10; i++) drive(1'b0);
    checks++;
    if (n_valid != v0 || n_ferr != f0 || n_perr != p0 || bus.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort: valid+%0d ferr+%0d perr+%0d busy=%b want 0/0/0/0",
               n_valid - v0, n_ferr - f0, n_perr - p0, bus.busy_o);
    end
    checks++;
    if ({bus.A_o, bus.B_o, bus.C_o} !== 12'h000) begin
      errors++;
      $display("FAIL reset_mid_data: got %h%h%h want 000", bus.A_o, bus.B_o, bus.C_o);
    end
    send_frame(4'hC, 4'hD, 4'hE, 1'b0, 1'b0);
    model_frame(4'hC, 4'hD, 4'hE, 1'b0, 1'b0);
    checks++;
    if (bus.valid_o !== 1'b1 || {bus.A_o, bus.B_o, bus.C_o} !== 12'hCDE) begin
      errors++;
      $display("FAIL after_reset_frame: valid=%b data=%h%h%h want 1/cde",
               bus.valid_o, bus.A_o, bus.B_o, bus.C_o);
    end
    drive(1'b0);
  endtask

  task automatic test_random;
    logic [3:0] a, b, c;
    logic       stop, pflip;
    int         gap, v0, exp_pulses;
    v0 = n_valid;
    exp_pulses = 0;
    for (int n = 0; n < 40; n++) begin
      a = 4'($urandom); b = 4'($urandom); c = 4'($urandom);
      stop  = ($urandom_range(0, 3) == 0);
      pflip = PAR_EN && ($urandom_range(0, 3) == 0);
      gap   = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) drive(1'b0);
      send_frame(a, b, c, stop, pflip);
      model_frame(a, b, c, stop, pflip);
      if (exp_valid) exp_pulses++;
      checks++;
      if (bus.valid_o !== exp_valid || bus.frame_err_o !== exp_ferr ||
          bus.parity_err_o !== exp_perr ||
          {bus.A_o, bus.B_o, bus.C_o} !== {exp_a, exp_b, exp_c}) begin
        errors++;
        $display("FAIL random_frame %0d: got v=%b fe=%b pe=%b d=%h%h%h want v=%b fe=%b pe=%b d=%h%h%h",
                 n, bus.valid_o, bus.frame_err_o, bus.parity_err_o, bus.A_o, bus.B_o, bus.C_o,
                 exp_valid, exp_ferr, exp_perr, exp_a, exp_b, exp_c);
      end
    end
    drive(1'b0);
    checks++;
    if (n_valid - v0 != exp_pulses) begin
      errors++;
      $display("FAIL random_pulse_count: got %0d want %0d", n_valid - v0, exp_pulses);
    end
  endtask

  initial begin
    reset   = 1'b1;
    bus.Yin = 1'b0;
    test_reset();
    test_good_frame();
    test_bad_stop();
`ifdef WEMBLEY_RX_PARITY_EN
    test_parity();
`endif
    test_back_to_back();
    test_reset_mid();
    test_random();
    checks++;
    if (!PAR_EN && n_perr != 0) begin
      errors++;
      $display("FAIL parity_tied_low: got %0d parity_err pulses want 0", n_perr);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
